pci_bus_arbiter: RTL

Central arbiter for the shared PCI-style bus. It takes the active-low `req` lines of every device slot and drives one active-low `gnt` per slot, with at most one grant active at a time. It monitors `Frame`/`IRDY` to track bus ownership, and uses a round-robin policy with a grant timeout so that no idle or broken master can starve the others. It sits at top level beside the device instances and replaces any testbench-driven `gnt` wiring.

---
 rtl/pci_bus_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/pci_bus_arbiter.sv
// Round-robin PCI bus arbiter with grant timeout and a turnaround cycle between masters.
// Ownership is tracked through Frame/IRDY; grants are registered, one-cold or all-high.
module pci_bus_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int GNT_TIMEOUT = 16,
  parameter int OWN_W       = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               areset,
  input  logic [NUM_REQ-1:0] req_n,
  input  logic               frame_n,
  input  logic               irdy_n,
  output logic [NUM_REQ-1:0] gnt_n,
  output logic [OWN_W-1:0]   owner,
  output logic               bus_busy,
  output logic               gnt_timeout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_BUSY  = 2'd2,
    S_TURN  = 2'd3
  } state_t;

  localparam logic [OWN_W-1:0] LAST_SLOT = OWN_W'(NUM_REQ - 1);
  localparam logic [7:0]       CNT_LAST  = 8'(GNT_TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_n_q, gnt_n_d;
  logic [OWN_W-1:0]     owner_q, owner_d;
  logic [OWN_W-1:0]     last_q, last_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 tmo_q, tmo_d;
  logic                 busy_q;
  logic                 bus_idle;
  logic                 found;
  logic [OWN_W-1:0]     winner;
  logic [OWN_W-1:0]     cand;

  assign bus_idle = frame_n & irdy_n;

  // Walk slots starting just after the most recent grantee; first active request wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = last_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = (cand == LAST_SLOT) ? '0 : cand + OWN_W'(1);
      if (!found && !req_n[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_n_d = gnt_n_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        gnt_n_d = '1;
        if (bus_idle && found) begin
          gnt_n_d[winner] = 1'b0;
          owner_d         = winner;
          last_d          = winner;
          cnt_d           = '0;
          state_d         = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!frame_n) begin
          state_d = S_BUSY;
        end else if (req_n[owner_q]) begin
          gnt_n_d = '1;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          gnt_n_d = '1;
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_BUSY: begin
        if (bus_idle) begin
          gnt_n_d = '1;
          state_d = S_TURN;
        end
      end
      S_TURN: begin
        gnt_n_d = '1;
        state_d = S_IDLE;
      end
      default: begin
        gnt_n_d = '1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      state_q <= S_IDLE;
      gnt_n_q <= '1;
      owner_q <= '0;
      last_q  <= LAST_SLOT;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_n_q <= gnt_n_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      busy_q  <= (state_d == S_BUSY);
    end
  end

  assign gnt_n       = gnt_n_q;
  assign owner       = owner_q;
  assign bus_busy    = busy_q;
  assign gnt_timeout = tmo_q;

endmodule
